serial_pair_serializer_msb_first: RTL

SERIAL_PAIR_SERIALIZER_MSB_FIRST -- requirements
Module: serial_pair_serializer_msb_first

---
 rtl/serial_pair_serializer_msb_first_if.sv | 34 +++
 rtl/serial_pair_serializer_msb_first.sv | 122 ++++++++++++
 2 files changed

// File: rtl/serial_pair_serializer_msb_first_if.sv
// serial_pair_serializer_msb_first_if
// Bundles the parallel operand handshake and the serial bit-pair stream of
// the MSB-first pair serializer.
//   in_valid/in_ready/in_a/in_b : parallel operand pair handshake
//   out_valid/out_ready         : serial bit-pair handshake
//   out_a/out_b                 : current bit of A and B, MSB first
//   out_first/out_last          : mark the MSB and LSB pairs of a word
// Modports:
//   master : the environment (drives operands and out_ready)
//   slave  : the serializer (accepts operands, drives the bit stream)
interface serial_pair_serializer_msb_first_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_ready;
  logic             out_valid;
  logic             out_a;
  logic             out_b;
  logic             out_first;
  logic             out_last;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_first, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_first, out_last
  );
endinterface

// File: rtl/serial_pair_serializer_msb_first.sv
// serial_pair_serializer_msb_first
// Accepts a parallel pair of WIDTH-bit operands and streams them out one bit
// pair per transfer, most significant bit first, with out_first on the MSB
// pair and out_last on the LSB pair so a serial comparator can restart.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : serial_pair_serializer_msb_first_if.slave (operand and bit stream)
// Optional feature:
//   SERIAL_PAIR_SERIALIZER_BACK_TO_BACK_EN - when defined, a new pair may be
//   accepted on the same edge that transfers the last bit of the current
//   word, removing the IDLE bubble between words.
module serial_pair_serializer_msb_first #(
  parameter int WIDTH = 8
) (
  input logic                              clk,
  input logic                              rst,
  serial_pair_serializer_msb_first_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             last_bit;
  logic             in_ready;
  logic             load;

  assign last_bit = (cnt_q == '0);

  // Ready in IDLE; with back-to-back enabled also on the last pair when
  // downstream is about to take it, so the next word follows without a gap.
  always_comb begin
    in_ready = (state_q == IDLE);
`ifdef SERIAL_PAIR_SERIALIZER_BACK_TO_BACK_EN
    if (state_q == SHIFT && last_bit && bus.out_ready) begin
      in_ready = 1'b1;
    end
`endif
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == SHIFT);
  assign bus.out_a     = (state_q == SHIFT) & sh_a_q[WIDTH-1];
  assign bus.out_b     = (state_q == SHIFT) & sh_b_q[WIDTH-1];
  assign bus.out_first = (state_q == SHIFT) & first_q;
  assign bus.out_last  = (state_q == SHIFT) & last_bit;

  // Next-state logic. Everything holds unless a transfer or a load happens,
  // which is what keeps a stalled pair stable while out_ready is low.
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.out_ready) begin
          if (!last_bit) begin
            sh_a_d  = sh_a_q << 1;
            sh_b_d  = sh_b_q << 1;
            cnt_d   = cnt_q - 1'b1;
            first_d = 1'b0;
          end else begin
            state_d = IDLE;
            first_d = 1'b0;
`ifdef SERIAL_PAIR_SERIALIZER_BACK_TO_BACK_EN
            if (bus.in_valid) begin
              load = 1'b1;
            end
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      sh_a_d  = bus.in_a;
      sh_b_d  = bus.in_b;
      cnt_d   = CW'(WIDTH - 1);
      first_d = 1'b1;
      state_d = SHIFT;
    end
  end

  // State register; reset discards any word in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

endmodule
